// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- the canonical RV32I NOP, used to fill idle queue slots.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One queue slot: the fetched word together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary; misalignment is not trapped here.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake and ROM bus between the fetch queue and its environment.
interface fetch_queue_if;
  import fetch_pkg::*;

  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;

  // Environment side: execute, the instruction ROM and decode.
  modport master (
    output fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
  );

  // Fetch queue side.
  modport slave (
    input  fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// Pop-and-push while full is accepted, so a full queue still streams.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow; a push into a full queue only lands
  // when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state pointers and occupancy; flush wins over push and pop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only at the tail, never modified in place.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage array is reset on purpose: the head is visible on the
    // outputs even when empty and must read as a clean NOP, never X.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, addresses the combinational instruction ROM,
// queues fetched words for decode and handles redirects from execute.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst_n,
  fetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_fire;
  logic            fetch_fire;
  fetch_entry_t    head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // The ROM address comes straight from the register so that neither
  // out_ready nor redirect_valid has a combinational path to it.
  assign bus.imem_addr = pc_q;

  assign out_fire   = ~fifo_empty & bus.out_ready;
  assign fetch_fire = bus.fetch_en & ~bus.redirect_valid & (~fifo_full | out_fire);

  // Next PC: redirect beats sequential advance; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = align_word(bus.redirect_pc);
    end else if (fetch_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // A redirect flushes the queue; a same-cycle pop is still treated as
  // consumed by decode since the redirecting instruction is older.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fetch_fire),
    .wdata_i ('{pc: pc_q, instr: bus.imem_instr}),
    .pop_i   (out_fire),
    .flush_i (bus.redirect_valid),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.out_valid    = (fifo_count != '0);
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ROM_KEY  = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model: expected PC and queued (pc, instr) pairs.
  logic [31:0] mpc;
  logic [31:0] qpc[$];
  logic [31:0] qins[$];

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction ROM.
  assign bus.imem_instr = bus.imem_addr ^ ROM_KEY;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model by one clock using the currently driven inputs, then
  // advance the DUT and stop at the following falling edge.
  task automatic step();
    bit fire_out;
    bit fire_fetch;
    fire_out   = (qpc.size() != 0) && bus.out_ready;
    fire_fetch = bus.fetch_en && !bus.redirect_valid &&
                 ((qpc.size() < DEPTH) || fire_out);
    if (bus.redirect_valid) begin
      mpc = {bus.redirect_pc[31:2], 2'b00};
      qpc.delete();
      qins.delete();
    end else begin
      if (fire_out) begin
        void'(qpc.pop_front());
        void'(qins.pop_front());
      end
      if (fire_fetch) begin
        qpc.push_back(mpc);
        qins.push_back(mpc ^ ROM_KEY);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    mpc = RESET_PC;
    qpc.delete();
    qins.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.fetch_en = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_instr !== 32'h13) begin
      errors++; $display("FAIL reset_instr got=%h want=00000013", bus.out_instr);
    end
    checks++;
    if (bus.out_pc !== 32'h0 || bus.out_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL reset_pc got=%h/%h want=0/4", bus.out_pc, bus.out_pc_plus4);
    end
    checks++;
    if (bus.imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_addr got=%h want=%h", bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_valid cyc=%0d got=%b want=1", k, bus.out_valid);
      end
      checks++;
      if (bus.out_pc !== 32'(4 * k) || bus.out_instr !== (32'(4 * k) ^ ROM_KEY) ||
          bus.out_pc_plus4 !== 32'(4 * k + 4)) begin
        errors++;
        $display("FAIL stream_data cyc=%0d got pc=%h instr=%h p4=%h want pc=%h",
                 k, bus.out_pc, bus.out_instr, bus.out_pc_plus4, 32'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (bus.imem_addr !== 32'h8 || bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got addr=%h pc=%h valid=%b want addr=8 pc=0 valid=1",
               bus.imem_addr, bus.out_pc, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL bp_release k=%0d got valid=%b pc=%h want pc=%h",
                 k, bus.out_valid, bus.out_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_flush();
    bus.out_ready = 1'b0;
    step(); step();
    checks++;
    if (qpc.size() != DEPTH || bus.out_pc !== qpc[0]) begin
      errors++; $display("FAIL flush_setup got pc=%h want full queue", bus.out_pc);
    end
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL flush_now got valid=%b addr=%h want valid=0 addr=100",
               bus.out_valid, bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== (32'h100 + 32'(4 * k))) begin
        errors++;
        $display("FAIL flush_after k=%0d got valid=%b pc=%h want pc=%h",
                 k, bus.out_valid, bus.out_pc, 32'h100 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_align_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    step();
    checks++;
    if (bus.imem_addr !== 32'h100) begin
      errors++; $display("FAIL align got addr=%h want=00000100", bus.imem_addr);
    end
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_first got pc=%h p4=%h want fffffffc/0", bus.out_pc, bus.out_pc_plus4);
    end
    step();
    checks++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== ROM_KEY) begin
      errors++;
      $display("FAIL wrap_second got pc=%h instr=%h want 0/%h", bus.out_pc, bus.out_instr, ROM_KEY);
    end
  endtask

  task automatic test_fetch_halt();
    logic [31:0] frozen;
    bus.out_ready = 1'b0;
    step(); step();
    bus.fetch_en = 1'b0;
    bus.out_ready = 1'b1;
    frozen = mpc;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.imem_addr !== frozen || bus.out_valid !== (qpc.size() != 0) ||
          (qpc.size() != 0 && bus.out_pc !== qpc[0])) begin
        errors++;
        $display("FAIL halt_drain k=%0d got addr=%h valid=%b pc=%h want addr=%h",
                 k, bus.imem_addr, bus.out_valid, bus.out_pc, frozen);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL halt_empty got valid=%b want=0", bus.out_valid);
    end
    bus.fetch_en = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== frozen) begin
      errors++;
      $display("FAIL halt_resume got valid=%b pc=%h want pc=%h", bus.out_valid, bus.out_pc, frozen);
    end
  endtask

  task automatic test_async_reset();
    bus.fetch_en = 1'b1;
    bus.out_ready = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL async_reset got valid=%b addr=%h want 0/%h",
               bus.out_valid, bus.imem_addr, RESET_PC);
    end
    mpc = RESET_PC;
    qpc.delete();
    qins.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin
      errors++;
      $display("FAIL async_restart got valid=%b pc=%h want pc=%h", bus.out_valid, bus.out_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus.fetch_en       = ($urandom_range(0, 9) != 0);
      bus.out_ready      = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = $urandom;
      step();
      checks++;
      if (bus.out_valid !== (qpc.size() != 0) || bus.imem_addr !== mpc) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got valid=%b addr=%h want valid=%b addr=%h",
                 k, bus.out_valid, bus.imem_addr, qpc.size() != 0, mpc);
      end
      if (qpc.size() != 0) begin
        checks++;
        if (bus.out_pc !== qpc[0] || bus.out_instr !== qins[0] ||
            bus.out_pc_plus4 !== qpc[0] + 32'd4) begin
          errors++;
          $display("FAIL rand_data cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                   k, bus.out_pc, bus.out_instr, qpc[0], qins[0]);
        end
      end
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mpc = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_align_wrap();
    test_fetch_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
